// File: rtl/stopwatch_display.sv
// Binary-to-BCD and seven-segment conversion of the stopwatch time fields.
// A snapshot is converted one double-dabble shift per cycle, then committed at once.
module stopwatch_display #(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [4:0]  days,
  input  logic [4:0]  hours,
  input  logic [5:0]  minutes,
  input  logic [5:0]  seconds,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd_out,
  output logic [55:0] hex_out
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [6:0]  SEG_ZERO  = 7'h40;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [55:0] HEX_RST   = BLANK_LEADING ? {SEG_BLANK, {7{SEG_ZERO}}}
                                                    : {8{SEG_ZERO}};

  state_t      state_q, state_d;
  logic [23:0] snap_q;    // {days, hours, minutes, seconds}, 6 bits each
  logic [1:0]  field_q;
  logic [2:0]  iter_q;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] stage_q;
  logic [31:0] bcd_q;
  logic [55:0] hex_q, hex_d;
  logic        done_q;

  logic [5:0]  cur_bin;
  logic [5:0]  cur_shift;
  logic [7:0]  acc_base;
  logic [3:0]  tens_adj, ones_adj;
  logic        last_iter;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd) state_d = CONV;
      CONV:    if (last_iter && (field_q == 2'd3)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    bcd_out = bcd_q;
    hex_out = hex_q;
  end

  // One double-dabble step; the binary MSB is picked from the snapshot so no
  // separate binary shift register has to be reloaded between fields.
  always_comb begin
    case (field_q)
      2'd0:    cur_bin = snap_q[5:0];
      2'd1:    cur_bin = snap_q[11:6];
      2'd2:    cur_bin = snap_q[17:12];
      default: cur_bin = snap_q[23:18];
    endcase
    cur_shift = cur_bin << iter_q;
    last_iter = (iter_q == 3'd5);
    acc_base  = (iter_q == 3'd0) ? 8'h00 : acc_q;
    tens_adj  = (acc_base[7:4] >= 4'd5) ? acc_base[7:4] + 4'd3 : acc_base[7:4];
    ones_adj  = (acc_base[3:0] >= 4'd5) ? acc_base[3:0] + 4'd3 : acc_base[3:0];
    acc_d     = {tens_adj[2:0], ones_adj, cur_shift[5]};
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_seg
      if (gi == 7) begin : g_lead
        always_comb begin
          if (BLANK_LEADING && (stage_q[31:28] == 4'd0)) hex_d[55:49] = SEG_BLANK;
          else                                           hex_d[55:49] = seg7(stage_q[31:28]);
        end
      end else begin : g_digit
        always_comb hex_d[7*gi +: 7] = seg7(stage_q[4*gi +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q  <= '0;
      field_q <= '0;
      iter_q  <= '0;
      acc_q   <= '0;
      stage_q <= '0;
      bcd_q   <= '0;
      hex_q   <= HEX_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (upd) begin
            snap_q  <= {1'b0, days, 1'b0, hours, minutes, seconds};
            field_q <= 2'd0;
            iter_q  <= 3'd0;
          end
        end
        CONV: begin
          acc_q <= acc_d;
          if (last_iter) begin
            stage_q[{field_q, 3'b000} +: 8] <= acc_d;
            iter_q  <= 3'd0;
            field_q <= field_q + 2'd1;
          end else begin
            iter_q <= iter_q + 3'd1;
          end
        end
        COMMIT: begin
          bcd_q  <= stage_q;
          hex_q  <= hex_d;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Converts the stopwatch time fields (days, hours, minutes, seconds) from binary into packed BCD and active-low seven-segment patterns for the eight HEX displays. It sits directly downstream of the stopwatch counter and upstream of the board HEX pins. Conversion is sequential: one double-dabble shift per cycle on a snapshot taken at request time. This keeps all eight digits coherent even when the counter ticks mid-conversion.

## Interface
Parameters:
- BLANK_LEADING, default 0: when 1, days-tens digit is blanked (7'h7F) whenever its value is 0.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- upd  input  1  conversion request; sampled only while idle.
- days  input  5  binary days, 0–31.
- hours  input  5  binary hours, 0–31 (nominal 0–23).
- minutes  input  6  binary minutes, 0–63 (nominal 0–59).
- seconds  input  6  binary seconds, 0–63 (nominal 0–59).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new outputs commit.
- bcd_out  output  32  packed BCD as {days, hours, minutes, seconds}, two nibbles per field, tens digit in the upper nibble.
- hex_out  output  56  segment patterns, 7 bits per digit, active-low, bit order {g,f,e,d,c,b,a}. Digit order from [6:0] upward: s-ones, s-tens, m-ones, m-tens, h-ones, h-tens, d-ones, d-tens.

Clock and reset are fixed: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE: if upd=1, capture all four inputs into a snapshot register. Zero-extend days and hours to 6 bits. Clear the field index and iteration counter. Go to CONV.
- CONV: one double-dabble iteration per cycle on the current field, ordered seconds, minutes, hours, days.
  - Each iteration, in one cycle: add 3 to each BCD nibble that is ≥5, then shift left by 1, bringing in the next binary MSB.
  - 6 iterations per field, 24 cycles total.
  - After the 6th iteration of a field, store its 8-bit BCD in a staging register and advance to the next field.
  - After the days field completes, go to COMMIT.
- COMMIT: copy staging to bcd_out. Encode all 8 digits into hex_out. Pulse done. Return to IDLE.
- Segment encoding (active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - BCD digits are always 0–9 by construction.
- Out-of-range inputs are converted faithfully, with no clamping: seconds=63 gives 0x63, hours=31 gives 0x31.
- upd while busy is ignored and not queued.
- Input changes after capture do not affect the result in progress.
- bcd_out and hex_out hold their last committed values between conversions.

## Timing
- Reset values:
  - busy=0, done=0, state IDLE.
  - bcd_out = 32'h0000_0000.
  - hex_out: all digits 7'h40 ("0"). With BLANK_LEADING=1, the days-tens digit is 7'h7F instead.
- Reset takes effect at the first clk edge with rst=1 and overrides every other input. Reset mid-conversion aborts it: outputs return to reset values and no done is issued.
- Latency, with upd sampled high at edge N (state IDLE):
  - busy=1 after edge N.
  - Edges N+1..N+24 perform the 24 iterations.
  - At edge N+25, outputs update, done=1 for exactly one cycle, and busy=0.
- Earliest next accepted request: upd sampled at edge N+26.
- Throughput: one conversion per 26 cycles.
- upd held high continuously restarts a conversion at each IDLE edge, i.e. every 26 cycles.
- done and busy are never high in the same cycle.

## Test plan
- Reset: assert rst for 2 cycles → bcd_out=0, hex_out=56'h81020408102040 (eight 7'h40), busy=0, done=0.
- Nominal conversion: days=0, hours=23, minutes=59, seconds=59, upd pulse → busy for 25 cycles, done exactly 25 cycles after accept.
  - bcd_out=32'h00235959.
  - hex_out seconds-ones field=7'h10, hours-tens field=7'h24.
- Blanking: BLANK_LEADING=1, days=5, hours=0, minutes=0, seconds=7 → bcd_out=32'h05000007, hex_out[55:49]=7'h7F, hex_out[48:42]=7'h12.
  - Repeat with days=31 → bcd_out=32'h31000007, tens digit=7'h30.
- Snapshot and ignore: accept seconds=10, then change seconds to 11 and pulse upd at cycle 5 of CONV → a single done; bcd_out[7:0]=8'h10; no second conversion starts.
- Abort: assert rst at cycle 10 of CONV → reset values on the next cycle, done never pulses; a following upd converts normally.
- Boundary: seconds=63, minutes=0, hours=31, days=31 → bcd_out=32'h31310063.
